// File: rtl/giaima_pkg.sv
// Shared definitions for the 3-to-8 sequenced decoder: state encoding,
// counter width and the one-hot decode helper.
package giaima_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // One-hot decode of a 3-bit code; exactly one bit set for any code.
  function automatic logic [7:0] onehot8(input logic [2:0] code);
    return 8'b1 << code;
  endfunction

endpackage

// File: rtl/giaima3_8_seq_if.sv
// Handshake and decode-output bundle of the sequenced 3-to-8 decoder.
// The master side supplies codes; the slave side is the decoder.
interface giaima3_8_seq_if;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic [7:0] out_onehot;
  logic       out_valid;
  logic       done;

  modport master (
    output in_valid, in_code,
    input  in_ready, out_onehot, out_valid, done
  );

  modport slave (
    input  in_valid, in_code,
    output in_ready, out_onehot, out_valid, done
  );
endinterface

// File: rtl/giaima_hold_cnt.sv
// Loadable down-counter shared by the HOLD and GAP windows. Load wins over
// decrement; decrementing stops at zero so the count can never wrap.
module giaima_hold_cnt
  import giaima_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_value,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Count register: reload on request, otherwise step down towards zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/giaima3_8_seq.sv
// Registered 3-to-8 decoder with valid/ready input handshake. An accepted
// code drives its one-hot line for HOLD cycles, followed by GAP all-zero
// cycles before the next code can be taken. All outputs come from registers
// or from decoding registered state, so nothing on the input side reaches
// an output combinationally.
module giaima3_8_seq
  import giaima_pkg::*;
#(
  parameter int HOLD = 4,   // 1..255
  parameter int GAP  = 1    // 0..255
) (
  input  logic              clk,
  input  logic              rst_n,
  giaima3_8_seq_if.slave    bus
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_code;
  logic             r_done;
  logic             w_done_next;
  logic             w_capture;
  logic             w_load;
  logic [CNT_W-1:0] w_load_value;
  logic             w_dec;
  logic             w_zero;

  giaima_hold_cnt u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .i_dec        (w_dec),
    .o_zero       (w_zero)
  );

  // State, captured code and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_code  <= 3'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
      if (w_capture) begin
        r_code <= bus.in_code;
      end
    end
  end

  // Next-state logic and counter control; ready is only high in IDLE so a
  // valid there is an acceptance.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    w_capture    = 1'b0;
    w_load       = 1'b0;
    w_load_value = '0;
    w_dec        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_state_next = ST_HOLD;
          w_capture    = 1'b1;
          w_load       = 1'b1;
          w_load_value = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (w_zero) begin
          w_done_next = 1'b1;
          if (GAP > 0) begin
            w_state_next = ST_GAP;
            w_load       = 1'b1;
            w_load_value = GAP_LOAD;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (w_zero) begin
          w_state_next = ST_IDLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready   = (r_state == ST_IDLE);
  assign bus.out_valid  = (r_state == ST_HOLD);
  assign bus.out_onehot = (r_state == ST_HOLD) ? onehot8(r_code) : 8'h00;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_giaima3_8_seq.sv
// Bench for giaima3_8_seq: three instances (HOLD/GAP = 4/1, 1/0, 255/255)
// checked against a timeline model built from acceptance times.
module tb_giaima3_8_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  giaima3_8_seq_if if_a ();
  giaima3_8_seq_if if_b ();
  giaima3_8_seq_if if_c ();

  giaima3_8_seq #(.HOLD(4),   .GAP(1))   dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  giaima3_8_seq #(.HOLD(1),   .GAP(0))   dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  giaima3_8_seq #(.HOLD(255), .GAP(255)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  logic       drv_valid [3];
  logic [2:0] drv_code  [3];

  assign if_a.in_valid = drv_valid[0];
  assign if_a.in_code  = drv_code[0];
  assign if_b.in_valid = drv_valid[1];
  assign if_b.in_code  = drv_code[1];
  assign if_c.in_valid = drv_valid[2];
  assign if_c.in_code  = drv_code[2];

  wire [7:0] o_oh [3];
  assign o_oh[0] = if_a.out_onehot;
  assign o_oh[1] = if_b.out_onehot;
  assign o_oh[2] = if_c.out_onehot;
  wire [2:0] o_v = {if_c.out_valid, if_b.out_valid, if_a.out_valid};
  wire [2:0] o_d = {if_c.done, if_b.done, if_a.done};
  wire [2:0] o_r = {if_c.in_ready, if_b.in_ready, if_a.in_ready};

  // Reference model: last acceptance cycle and code per instance.
  // Cycle index c is the interval following rising edge c.
  bit         has   [3];
  int         acc   [3];
  logic [2:0] mcode [3];

  function automatic int hp(int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 255;
  endfunction
  function automatic int gp(int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 255;
  endfunction
  function automatic int dd(int k);
    return cyc - acc[k];
  endfunction
  function automatic bit m_ready(int k);
    return !has[k] || (dd(k) >= hp(k) + gp(k));
  endfunction
  function automatic bit m_valid(int k);
    return has[k] && (dd(k) < hp(k));
  endfunction
  function automatic bit m_done(int k);
    return has[k] && (dd(k) == hp(k));
  endfunction
  function automatic logic [7:0] m_oh(int k);
    return m_valid(k) ? (8'd1 << mcode[k]) : 8'd0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) has[k] <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (drv_valid[k] && m_ready(k)) begin
          has[k]   <= 1'b1;
          acc[k]   <= cyc + 1;
          mcode[k] <= drv_code[k];
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drv_valid[k] = 1'b0;
      drv_code[k]  = 3'd0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_oh[k] !== 8'h00 || o_v[k] !== 1'b0 || o_d[k] !== 1'b0 || o_r[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset dut%0d got oh=%h v=%b d=%b r=%b exp oh=00 v=0 d=0 r=1",
                 k, o_oh[k], o_v[k], o_d[k], o_r[k]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_oh[k] !== 8'h00 || o_v[k] !== 1'b0 || o_d[k] !== 1'b0 || o_r[k] !== 1'b1) begin
          errors++;
          $display("FAIL idle dut%0d cyc=%0d got oh=%h v=%b d=%b r=%b exp oh=00 v=0 d=0 r=1",
                   k, cyc, o_oh[k], o_v[k], o_d[k], o_r[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    drv_valid[0] = 1'b1;
    drv_code[0]  = 3'd5;
    @(negedge clk);
    drv_valid[0] = 1'b0;
    checks++;
    if (o_oh[0] !== 8'h20) begin
      errors++;
      $display("FAIL rst_mid_first got oh=%h exp oh=20", o_oh[0]);
    end
    @(negedge clk);
    checks++;
    if (o_oh[0] !== 8'h20 || o_v[0] !== 1'b1 || o_r[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_before got oh=%h v=%b r=%b exp oh=20 v=1 r=0", o_oh[0], o_v[0], o_r[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_oh[0] !== 8'h00 || o_v[0] !== 1'b0 || o_d[0] !== 1'b0 || o_r[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_async got oh=%h v=%b d=%b r=%b exp oh=00 v=0 d=0 r=1",
               o_oh[0], o_v[0], o_d[0], o_r[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    int idx = 0;
    int dones = 0;
    int rises = 0;
    int last_rise = -1;
    int seen [8];
    logic [7:0] prev = 8'h00;
    for (int c = 0; c < 8; c++) seen[c] = 0;
    drv_valid[0] = 1'b1;
    drv_code[0]  = 3'd0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_oh[k] !== m_oh(k) || o_v[k] !== m_valid(k) || o_d[k] !== m_done(k) || o_r[k] !== m_ready(k)) begin
          errors++;
          $display("FAIL sweep_model dut%0d cyc=%0d got oh=%h v=%b d=%b r=%b exp oh=%h v=%b d=%b r=%b",
                   k, cyc, o_oh[k], o_v[k], o_d[k], o_r[k], m_oh(k), m_valid(k), m_done(k), m_ready(k));
        end
      end
      if (o_d[0] === 1'b1) dones++;
      for (int c = 0; c < 8; c++) if (o_oh[0] === (8'd1 << c)) seen[c]++;
      if (prev === 8'h00 && o_oh[0] !== 8'h00) begin
        if (last_rise >= 0) begin
          checks++;
          if (cyc - last_rise !== 6) begin
            errors++;
            $display("FAIL sweep_spacing got %0d cycles exp 6", cyc - last_rise);
          end
        end
        last_rise = cyc;
        rises++;
      end
      prev = o_oh[0];
      if (idx < 8 && has[0] && acc[0] == cyc) begin
        idx++;
        if (idx == 8) drv_valid[0] = 1'b0;
        else drv_code[0] = 3'(idx);
      end
    end
    drv_valid[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (seen[c] !== 4) begin
        errors++;
        $display("FAIL sweep_window code%0d got %0d cycles exp 4", c, seen[c]);
      end
    end
    checks++;
    if (dones !== 8 || rises !== 8 || idx !== 8) begin
      errors++;
      $display("FAIL sweep_count got done=%0d windows=%0d accepts=%0d exp 8 8 8", dones, rises, idx);
    end
  endtask

  task automatic test_input_change();
    int c08 = 0;
    int c40 = 0;
    int first40 = -1;
    drv_valid[0] = 1'b1;
    drv_code[0]  = 3'd3;
    @(negedge clk);
    drv_code[0] = 3'd6;
    for (int n = 0; n < 14; n++) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_oh[k] !== m_oh(k) || o_v[k] !== m_valid(k) || o_d[k] !== m_done(k) || o_r[k] !== m_ready(k)) begin
          errors++;
          $display("FAIL change_model dut%0d cyc=%0d got oh=%h v=%b d=%b r=%b exp oh=%h v=%b d=%b r=%b",
                   k, cyc, o_oh[k], o_v[k], o_d[k], o_r[k], m_oh(k), m_valid(k), m_done(k), m_ready(k));
        end
      end
      if (o_oh[0] === 8'h08) c08++;
      if (o_oh[0] === 8'h40) begin
        c40++;
        if (first40 < 0) first40 = n;
        drv_valid[0] = 1'b0;
      end
      @(negedge clk);
    end
    drv_valid[0] = 1'b0;
    checks++;
    if (c08 !== 4 || c40 !== 4 || first40 !== 6) begin
      errors++;
      $display("FAIL change_window got c08=%0d c40=%0d first40=%0d exp 4 4 6", c08, c40, first40);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_gap0();
    drv_valid[1] = 1'b1;
    drv_code[1]  = 3'd2;
    @(negedge clk);
    drv_code[1] = 3'd7;
    checks++;
    if (o_oh[1] !== 8'h04 || o_d[1] !== 1'b0) begin
      errors++;
      $display("FAIL gap0_first got oh=%h d=%b exp oh=04 d=0", o_oh[1], o_d[1]);
    end
    @(negedge clk);
    checks++;
    if (o_oh[1] !== 8'h00 || o_d[1] !== 1'b1 || o_r[1] !== 1'b1) begin
      errors++;
      $display("FAIL gap0_between got oh=%h d=%b r=%b exp oh=00 d=1 r=1", o_oh[1], o_d[1], o_r[1]);
    end
    @(negedge clk);
    drv_valid[1] = 1'b0;
    checks++;
    if (o_oh[1] !== 8'h80 || o_d[1] !== 1'b0) begin
      errors++;
      $display("FAIL gap0_second got oh=%h d=%b exp oh=80 d=0", o_oh[1], o_d[1]);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_oh[k] !== m_oh(k) || o_v[k] !== m_valid(k) || o_d[k] !== m_done(k) || o_r[k] !== m_ready(k)) begin
          errors++;
          $display("FAIL gap0_model dut%0d cyc=%0d got oh=%h v=%b d=%b r=%b exp oh=%h v=%b d=%b r=%b",
                   k, cyc, o_oh[k], o_v[k], o_d[k], o_r[k], m_oh(k), m_valid(k), m_done(k), m_ready(k));
        end
      end
    end
  endtask

  task automatic test_corner();
    int n02 = 0;
    int nz = 0;
    bit got_ready = 1'b0;
    drv_valid[2] = 1'b1;
    drv_code[2]  = 3'd1;
    @(negedge clk);
    drv_valid[2] = 1'b0;
    for (int n = 0; n < 600 && !got_ready; n++) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_oh[k] !== m_oh(k) || o_v[k] !== m_valid(k) || o_d[k] !== m_done(k) || o_r[k] !== m_ready(k)) begin
          errors++;
          $display("FAIL corner_model dut%0d cyc=%0d got oh=%h v=%b d=%b r=%b exp oh=%h v=%b d=%b r=%b",
                   k, cyc, o_oh[k], o_v[k], o_d[k], o_r[k], m_oh(k), m_valid(k), m_done(k), m_ready(k));
        end
      end
      if (o_r[2] === 1'b1) got_ready = 1'b1;
      else if (o_oh[2] === 8'h02) n02++;
      else if (o_oh[2] === 8'h00) nz++;
      if (!got_ready) @(negedge clk);
    end
    checks++;
    if (n02 !== 255 || nz !== 255 || got_ready !== 1'b1) begin
      errors++;
      $display("FAIL corner_window got hold=%0d gap=%0d ready=%b exp 255 255 1", n02, nz, got_ready);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_oh[k] !== m_oh(k) || o_v[k] !== m_valid(k) || o_d[k] !== m_done(k) || o_r[k] !== m_ready(k)) begin
          errors++;
          $display("FAIL random_model dut%0d cyc=%0d got oh=%h v=%b d=%b r=%b exp oh=%h v=%b d=%b r=%b",
                   k, cyc, o_oh[k], o_v[k], o_d[k], o_r[k], m_oh(k), m_valid(k), m_done(k), m_ready(k));
        end
      end
      for (int k = 0; k < 3; k++) begin
        drv_valid[k] = 1'($urandom_range(0, 1));
        drv_code[k]  = 3'($urandom_range(0, 7));
      end
    end
    for (int k = 0; k < 3; k++) drv_valid[k] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_reset_mid_hold();
    test_sweep();
    test_input_change();
    test_gap0();
    test_corner();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/giaima3_8_seq.md
# giaima3_8_seq

Registered 3-to-8 decoder with a valid/ready input handshake and a programmable output hold window. It accepts a 3-bit binary code and drives the matching one-hot line for a fixed number of cycles, then a fixed idle gap. It pairs with the 8-to-3 encoder in the same design, turning encoded selections back into one-hot strobes for downstream select/enable logic.

## Interface
- HOLD, 4: cycles the one-hot output stays asserted per accepted code; legal range 1..255.
- GAP, 1: cycles of all-zero output after the hold window before the next code is accepted; legal range 0..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  in_code is valid this cycle.
- in_code  input  3  binary code 0..7 to decode.
- in_ready  output  1  block can accept a code this cycle.
- out_onehot  output  8  one-hot decode of the captured code; bit n set for code n.
- out_valid  output  1  out_onehot carries a live decode.
- done  output  1  single-cycle pulse when a hold window ends.

## Operation
- States:
  - IDLE: in_ready=1, out_onehot=0, out_valid=0.
  - HOLD: out_onehot = 1 << captured code, out_valid=1, in_ready=0.
  - GAP: out_onehot=0, out_valid=0, in_ready=0.
- in_ready is a pure function of state: it is 1 only in IDLE.
- Acceptance: a code is accepted on a rising edge where in_valid=1 and in_ready=1.
  - in_code is captured into an internal 3-bit register at acceptance.
  - Changes on in_code after acceptance have no effect.
- IDLE -> HOLD on acceptance. The down-counter is loaded with HOLD-1.
- HOLD: the counter decrements each cycle. At count 0:
  - If GAP>0, go to GAP and load the counter with GAP-1.
  - If GAP=0, go to IDLE.
- GAP: the counter decrements each cycle. At count 0, go to IDLE.
- in_valid while not in IDLE is ignored. No queuing; the upstream holds in_valid until it sees in_ready.
- done=1 for exactly one cycle: the first cycle after the last HOLD cycle, whether the block is then in GAP or IDLE.
- out_onehot is exactly one-hot in HOLD and all-zero otherwise. It is never multi-hot, including during transitions.
- All outputs are registered or decoded from registered state. There is no combinational path from in_valid or in_code to any output.
- Counter width is 8 bits. No wrap-around occurs because the counter is reloaded before it can underflow.

## Timing
- Reset (rst_n=0, at any time, including mid-HOLD or mid-GAP) forces all of the following immediately, without waiting for a clock edge:
  - state=IDLE, counter=0, captured code=0.
  - out_onehot=8'h00, out_valid=0, done=0, in_ready=1.
- After rst_n deasserts, the first acceptance can occur on the first rising edge.
- Latency: code accepted at edge k -> out_onehot valid from edge k+1 through edge k+HOLD (HOLD cycles).
- done is high in cycle k+HOLD+1.
- in_ready returns to 1 at edge k+HOLD+GAP+1. Minimum code spacing is HOLD+GAP+1 cycles.
- Back-to-back: if in_valid is held high, a new code is accepted on the first IDLE edge.
  - With GAP=0 there is exactly one all-zero cycle between hold windows. That cycle is the one where done=1.

## Structure
- Shared package giaima_pkg:
  - state encoding constants ST_IDLE, ST_HOLD, ST_GAP (2 bits).
  - function onehot8(code) returning 8'b1 << code.
  - counter width constant CNT_W=8.
- Sub-module giaima_hold_cnt:
  - loadable 8-bit down-counter with load, load_value, dec and zero outputs.
  - same clk/rst_n.
  - instantiated once and shared by HOLD and GAP.
- Top level holds the FSM, the code capture register and the output decode.

## Test plan
- Reset mid-HOLD:
  - Accept code 5 (HOLD=4, GAP=1).
  - Assert rst_n=0 two cycles later -> out_onehot=8'h00, out_valid=0, in_ready=1 immediately, without a clock edge.
- Full sweep:
  - Accept codes 0..7 in order with in_valid held high.
  - Required: each window shows 8'h01, 8'h02, ... 8'h80 for exactly 4 cycles.
  - Required: done pulses once per window.
  - Required: accepted codes are spaced 6 cycles apart.
- Input changes during HOLD:
  - Accept code 3, then drive in_code=6 with in_valid=1 during HOLD.
  - Required: out_onehot stays 8'h08 for the whole window.
  - Required: code 6 is accepted only once in_ready=1.
- GAP=0, HOLD=1:
  - Accept codes 2 then 7 back-to-back.
  - Required sequence: 8'h04, then 8'h00 with done=1, then 8'h80.
- Corner parameters HOLD=255, GAP=255:
  - Accept code 1.
  - Required: 8'h02 for exactly 255 cycles, 255 zero cycles, then in_ready=1.
- Handshake idle:
  - in_valid=0 for 20 cycles -> in_ready=1 throughout.
  - Required: out_onehot=0, out_valid=0 and done=0 throughout.
